// File: rtl/ds_pkg.sv
// Shared state encoding and default widths for the downstream TX arbiter.
// The defaults describe a 256-bit datapath carrying packets of up to 1536 bytes.
package ds_pkg;

   localparam int DS_DATA_W    = 256;
   localparam int DS_KEEP_W    = 32;
   localparam int DS_USER_W    = 128;
   localparam int DS_MAX_BEATS = 48;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } ds_state_t;

endpackage

// File: rtl/ds_rr_arb2.sv
// Two-way round-robin grant: the pointed-to requester wins, else the other one.
// Purely combinational; gives an all-zero grant when nothing requests.
module ds_rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_rr,
   output logic [1:0] o_gnt
);

   always_comb begin
      o_gnt = 2'b00;
      if (i_req[i_rr]) begin
         o_gnt[i_rr] = 1'b1;
      end else if (i_req[~i_rr]) begin
         o_gnt[~i_rr] = 1'b1;
      end
   end

endmodule

// File: rtl/ds_tx_arbiter.sv
// Merges two AXI-stream sources onto the FAST packet input, one packet at a time.
// Beats appear one cycle after acceptance; the granted source follows pktin_ready.
module ds_tx_arbiter
   import ds_pkg::*;
#(
   parameter int DATA_W    = DS_DATA_W,
   parameter int KEEP_W    = DS_KEEP_W,
   parameter int USER_W    = DS_USER_W,
   parameter int MAX_BEATS = DS_MAX_BEATS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s0_axis_tdata,
   input  logic [KEEP_W-1:0] s0_axis_tkeep,
   input  logic [USER_W-1:0] s0_axis_tuser,
   input  logic              s0_axis_tvalid,
   input  logic              s0_axis_tlast,
   output logic              s0_axis_tready,
   input  logic [DATA_W-1:0] s1_axis_tdata,
   input  logic [KEEP_W-1:0] s1_axis_tkeep,
   input  logic [USER_W-1:0] s1_axis_tuser,
   input  logic              s1_axis_tvalid,
   input  logic              s1_axis_tlast,
   output logic              s1_axis_tready,
   output logic [DATA_W-1:0] pktin_data,
   output logic [KEEP_W-1:0] pktin_keep,
   output logic [USER_W-1:0] pktin_user,
   output logic              pktin_data_wr,
   output logic              pktin_data_valid_wr,
   output logic              pktin_data_valid,
   input  logic              pktin_ready,
   output logic [31:0]       pkt_cnt0,
   output logic [31:0]       pkt_cnt1,
   output logic [31:0]       err_cnt
);

   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   ds_state_t          r_state;
   logic               r_gnt;
   logic               r_rr;
   logic [CNT_W-1:0]   r_beats;
   logic [DATA_W-1:0]  r_data;
   logic [KEEP_W-1:0]  r_keep;
   logic [USER_W-1:0]  r_user;
   logic               r_wr;
   logic               r_vwr;
   logic               r_v;
   logic [31:0]        r_cnt0;
   logic [31:0]        r_cnt1;
   logic [31:0]        r_err;

   logic [1:0]         w_vld;
   logic [1:0]         w_arb_gnt;
   logic [1:0]         w_rdy;
   logic               w_sel_vld;
   logic               w_sel_last;
   logic [DATA_W-1:0]  w_sel_data;
   logic [KEEP_W-1:0]  w_sel_keep;
   logic [USER_W-1:0]  w_sel_user;
   logic               w_acc;
   logic               w_max_beat;

   assign w_vld = {s1_axis_tvalid, s0_axis_tvalid};

   ds_rr_arb2 u_arb (
      .i_req (w_vld),
      .i_rr  (r_rr),
      .o_gnt (w_arb_gnt)
   );

   assign w_sel_vld  = r_gnt ? s1_axis_tvalid : s0_axis_tvalid;
   assign w_sel_last = r_gnt ? s1_axis_tlast  : s0_axis_tlast;
   assign w_sel_data = r_gnt ? s1_axis_tdata  : s0_axis_tdata;
   assign w_sel_keep = r_gnt ? s1_axis_tkeep  : s0_axis_tkeep;
   assign w_sel_user = r_gnt ? s1_axis_tuser  : s0_axis_tuser;

   // DRAIN swallows the rest of an oversize packet even while FAST is full.
   always_comb begin
      w_rdy = 2'b00;
      if (!rst) begin
         case (r_state)
            BUSY:    w_rdy[r_gnt] = pktin_ready;
            DRAIN:   w_rdy[r_gnt] = 1'b1;
            default: w_rdy = 2'b00;
         endcase
      end
   end

   assign s0_axis_tready = w_rdy[0];
   assign s1_axis_tready = w_rdy[1];

   assign w_acc      = w_sel_vld & w_rdy[r_gnt];
   assign w_max_beat = (r_beats == CNT_W'(MAX_BEATS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_gnt   <= 1'b0;
         r_rr    <= 1'b0;
         r_beats <= '0;
         r_data  <= '0;
         r_keep  <= '0;
         r_user  <= '0;
         r_wr    <= 1'b0;
         r_vwr   <= 1'b0;
         r_v     <= 1'b0;
         r_cnt0  <= '0;
         r_cnt1  <= '0;
         r_err   <= '0;
      end else begin
         r_wr  <= 1'b0;
         r_vwr <= 1'b0;
         r_v   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (pktin_ready && (|w_arb_gnt)) begin
                  r_gnt   <= w_arb_gnt[1];
                  r_beats <= '0;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (w_acc) begin
                  r_beats <= r_beats + CNT_W'(1);
                  r_wr    <= 1'b1;
                  r_data  <= w_sel_data;
                  r_keep  <= w_sel_keep;
                  if (r_beats == '0) begin
                     r_user <= w_sel_user;
                  end
                  if (w_sel_last) begin
                     r_vwr   <= 1'b1;
                     r_v     <= 1'b1;
                     r_rr    <= ~r_gnt;
                     r_state <= IDLE;
                     if (r_gnt) begin
                        r_cnt1 <= r_cnt1 + 32'd1;
                     end else begin
                        r_cnt0 <= r_cnt0 + 32'd1;
                     end
                  end else if (w_max_beat) begin
                     // Oversize: close the packet as errored, discard the tail.
                     r_vwr   <= 1'b1;
                     r_err   <= r_err + 32'd1;
                     r_state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (w_acc && w_sel_last) begin
                  r_rr    <= ~r_gnt;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign pktin_data          = r_data;
   assign pktin_keep          = r_keep;
   assign pktin_user          = r_user;
   assign pktin_data_wr       = r_wr;
   assign pktin_data_valid_wr = r_vwr;
   assign pktin_data_valid    = r_v;
   assign pkt_cnt0            = r_cnt0;
   assign pkt_cnt1            = r_cnt1;
   assign err_cnt             = r_err;

endmodule

// File: tb/tb_ds_tx_arbiter.sv
// Bench for ds_tx_arbiter: packet-level source queues, a rule-based reference
// model compared every cycle, and literal expectations for the directed scenarios.
module tb_ds_tx_arbiter;
   import ds_pkg::*;

   localparam int MAXB = DS_MAX_BEATS;

   typedef struct packed {
      logic [DS_DATA_W-1:0] data;
      logic [DS_KEEP_W-1:0] keep;
      logic [DS_USER_W-1:0] user;
      logic                 last;
   } beat_t;

   typedef struct {
      int          cyc;
      logic [31:0] lo;
      logic        vw;
      logic        v;
   } log_t;

   logic                 clk;
   logic                 rst;
   logic [DS_DATA_W-1:0] s0_axis_tdata, s1_axis_tdata;
   logic [DS_KEEP_W-1:0] s0_axis_tkeep, s1_axis_tkeep;
   logic [DS_USER_W-1:0] s0_axis_tuser, s1_axis_tuser;
   logic                 s0_axis_tvalid, s1_axis_tvalid;
   logic                 s0_axis_tlast, s1_axis_tlast;
   logic                 s0_axis_tready, s1_axis_tready;
   logic [DS_DATA_W-1:0] pktin_data;
   logic [DS_KEEP_W-1:0] pktin_keep;
   logic [DS_USER_W-1:0] pktin_user;
   logic                 pktin_data_wr, pktin_data_valid_wr, pktin_data_valid;
   logic                 pktin_ready;
   logic [31:0]          pkt_cnt0, pkt_cnt1, err_cnt;

   ds_tx_arbiter dut (
      .clk(clk), .rst(rst),
      .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
      .s0_axis_tuser(s0_axis_tuser), .s0_axis_tvalid(s0_axis_tvalid),
      .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
      .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
      .s1_axis_tuser(s1_axis_tuser), .s1_axis_tvalid(s1_axis_tvalid),
      .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
      .pktin_data(pktin_data), .pktin_keep(pktin_keep), .pktin_user(pktin_user),
      .pktin_data_wr(pktin_data_wr), .pktin_data_valid_wr(pktin_data_valid_wr),
      .pktin_data_valid(pktin_data_valid), .pktin_ready(pktin_ready),
      .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .err_cnt(err_cnt)
   );

   int n_vec = 0;
   int n_mis = 0;
   int cyc   = 0;

   beat_t q0[$];
   beat_t q1[$];
   log_t  lg[$];

   logic want_rst   = 1'b1;
   logic want_ready = 1'b1;

   // reference model: packet phase 0 = idle, 1 = forwarding, 2 = dropping
   int                   m_phase = 0;
   logic                 m_port  = 1'b0;
   logic                 m_rr    = 1'b0;
   int                   m_n     = 0;
   logic [31:0]          m_cnt0 = '0, m_cnt1 = '0, m_err = '0;
   logic                 e_wr = 1'b0, e_vw = 1'b0, e_v = 1'b0, e_zero = 1'b0;
   logic [DS_DATA_W-1:0] e_data = '0;
   logic [DS_KEEP_W-1:0] e_keep = '0;
   logic [DS_USER_W-1:0] e_user = '0;
   logic                 m_started = 1'b0;

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic beat_t front(input logic p);
      beat_t b;
      b = '0;
      if (p && q1.size() > 0) b = q1[0];
      if (!p && q0.size() > 0) b = q0[0];
      return b;
   endfunction

   function automatic void pop(input logic p);
      if (p) void'(q1.pop_front());
      else void'(q0.pop_front());
   endfunction

   task automatic push_pkt(input int p, input int n, input int id);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         for (int w = 0; w < 8; w++) b.data[w*32 +: 32] = $urandom;
         b.data[31:0] = {id[7:0], p[7:0], i[15:0]};
         b.keep = (i == n - 1) ? 32'h0000_ffff : 32'hffff_ffff;
         b.user = {$urandom, $urandom, $urandom, id[7:0], p[7:0], 16'h0};
         b.last = (i == n - 1);
         if (p == 1) q1.push_back(b);
         else q0.push_back(b);
      end
   endtask

   // Driver + model + per-cycle compare, all on the falling edge.
   initial begin
      beat_t b0, b1, b;
      logic  t0, t1, v;
      rst = 1'b1; pktin_ready = 1'b1;
      s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
      s0_axis_tdata = '0; s0_axis_tkeep = '0; s0_axis_tuser = '0; s0_axis_tlast = 1'b0;
      s1_axis_tdata = '0; s1_axis_tkeep = '0; s1_axis_tuser = '0; s1_axis_tlast = 1'b0;
      forever begin
         @(negedge clk);
         if (m_started) begin
            chk("data_wr", pktin_data_wr, e_wr);
            chk("valid_wr", pktin_data_valid_wr, e_vw);
            chk("valid", pktin_data_valid, e_v);
            chk("user", pktin_user, e_user);
            chk("pkt_cnt0", pkt_cnt0, m_cnt0);
            chk("pkt_cnt1", pkt_cnt1, m_cnt1);
            chk("err_cnt", err_cnt, m_err);
            if (e_wr || e_zero) begin
               chk("data", pktin_data, e_data);
               chk("keep", pktin_keep, e_keep);
            end
            if (pktin_data_wr === 1'b1)
               lg.push_back('{cyc, pktin_data[31:0], pktin_data_valid_wr, pktin_data_valid});
         end
         cyc++;
         rst = want_rst;
         pktin_ready = want_ready;
         b0 = front(1'b0);
         b1 = front(1'b1);
         s0_axis_tvalid = (q0.size() > 0);
         s0_axis_tdata = b0.data; s0_axis_tkeep = b0.keep;
         s0_axis_tuser = b0.user; s0_axis_tlast = b0.last;
         s1_axis_tvalid = (q1.size() > 0);
         s1_axis_tdata = b1.data; s1_axis_tkeep = b1.keep;
         s1_axis_tuser = b1.user; s1_axis_tlast = b1.last;
         #1;
         t0 = 1'b0; t1 = 1'b0;
         if (!rst && m_phase != 0) begin
            if (m_port) t1 = (m_phase == 2) ? 1'b1 : pktin_ready;
            else        t0 = (m_phase == 2) ? 1'b1 : pktin_ready;
         end
         chk("tready0", s0_axis_tready, t0);
         chk("tready1", s1_axis_tready, t1);
         e_wr = 1'b0; e_vw = 1'b0; e_v = 1'b0; e_zero = 1'b0;
         if (rst) begin
            m_phase = 0; m_rr = 1'b0; m_port = 1'b0; m_n = 0;
            m_cnt0 = '0; m_cnt1 = '0; m_err = '0;
            e_data = '0; e_keep = '0; e_user = '0; e_zero = 1'b1;
         end else begin
            v = m_port ? s1_axis_tvalid : s0_axis_tvalid;
            b = m_port ? b1 : b0;
            if (m_phase == 0) begin
               if (pktin_ready && (s0_axis_tvalid || s1_axis_tvalid)) begin
                  m_port  = (m_rr ? s1_axis_tvalid : s0_axis_tvalid) ? m_rr : ~m_rr;
                  m_phase = 1;
                  m_n     = 0;
               end
            end else if (m_phase == 1) begin
               if (v && pktin_ready) begin
                  pop(m_port);
                  m_n++;
                  e_wr = 1'b1; e_data = b.data; e_keep = b.keep;
                  if (m_n == 1) e_user = b.user;
                  if (b.last) begin
                     e_vw = 1'b1; e_v = 1'b1;
                     if (m_port) m_cnt1 = m_cnt1 + 1;
                     else m_cnt0 = m_cnt0 + 1;
                     m_rr = ~m_port; m_phase = 0;
                  end else if (m_n == MAXB) begin
                     e_vw = 1'b1; m_err = m_err + 1; m_phase = 2;
                  end
               end
            end else begin
               if (v) begin
                  pop(m_port);
                  if (b.last) begin
                     m_rr = ~m_port; m_phase = 0;
                  end
               end
            end
         end
         m_started = 1'b1;
      end
   end

   task automatic do_reset();
      @(posedge clk);
      want_rst = 1'b1;
      q0.delete(); q1.delete();
      repeat (2) @(posedge clk);
      want_rst = 1'b0;
      @(posedge clk);
      lg.delete();
   endtask

   task automatic wait_idle(input int budget);
      logic done;
      for (int k = 0; k < budget; k++) begin
         if (q0.size() == 0 && q1.size() == 0 && m_phase == 0) break;
         @(posedge clk);
      end
      done = (q0.size() == 0 && q1.size() == 0 && m_phase == 0);
      chk("drain_done", done, 1'b1);
      repeat (3) @(posedge clk);
   endtask

   task automatic wait_log(input int n, input int budget);
      logic done;
      for (int k = 0; k < budget; k++) begin
         if (lg.size() >= n) break;
         @(posedge clk);
      end
      done = (lg.size() >= n);
      chk("log_reached", done, 1'b1);
   endtask

   initial begin
      int sz;
      do_reset();
      @(negedge clk);
      chk("rst_data", pktin_data, '0);
      chk("rst_cnt0", pkt_cnt0, 32'd0);
      chk("rst_tready0", s0_axis_tready, 1'b0);

      // Simultaneous 3-beat packets: port 0 first, port 1 after one arbitration gap.
      @(posedge clk);
      push_pkt(0, 3, 1); push_pkt(1, 3, 2);
      wait_idle(200);
      chk("s1_log_size", lg.size(), 6);
      for (int i = 0; i < 6 && i < lg.size(); i++)
         chk("s1_order", lg[i].lo[23:0], {8'(i / 3), 16'(i % 3)});
      if (lg.size() >= 4) begin
         chk("s1_beat_gap", lg[1].cyc - lg[0].cyc, 1);
         chk("s1_pkt_gap", lg[3].cyc - lg[2].cyc, 2);
      end
      chk("s1_cnt0", pkt_cnt0, 32'd1);
      chk("s1_cnt1", pkt_cnt1, 32'd1);

      // Two single-beat packets on port 1 only.
      do_reset();
      push_pkt(1, 1, 3); push_pkt(1, 1, 4);
      wait_idle(200);
      chk("s2_log_size", lg.size(), 2);
      if (lg.size() >= 2) begin
         chk("s2_gap", lg[1].cyc - lg[0].cyc, 2);
         chk("s2_vw0", lg[0].vw, 1'b1);
         chk("s2_vw1", lg[1].vw, 1'b1);
      end
      chk("s2_cnt1", pkt_cnt1, 32'd2);

      // FAST backpressure for 4 cycles in the middle of a 6-beat packet.
      do_reset();
      push_pkt(0, 6, 5);
      wait_log(2, 100);
      want_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("s3_tready_held", s0_axis_tready, 1'b0);
      chk("s3_wr_held", pktin_data_wr, 1'b0);
      repeat (2) @(posedge clk);
      want_ready = 1'b1;
      wait_idle(200);
      chk("s3_log_size", lg.size(), 6);
      for (int i = 0; i < 6 && i < lg.size(); i++)
         chk("s3_order", lg[i].lo[15:0], 16'(i));

      // 50-beat oversize packet on port 0 with port 1 waiting.
      do_reset();
      push_pkt(0, 50, 6); push_pkt(1, 2, 7);
      wait_idle(400);
      chk("s4_log_size", lg.size(), MAXB + 2);
      if (lg.size() >= MAXB + 2) begin
         chk("s4_last_port", lg[MAXB-1].lo[23:0], {8'd0, 16'(MAXB - 1)});
         chk("s4_err_vw", lg[MAXB-1].vw, 1'b1);
         chk("s4_err_v", lg[MAXB-1].v, 1'b0);
         chk("s4_next_port", lg[MAXB].lo[23:16], 8'd1);
      end
      chk("s4_err_cnt", err_cnt, 32'd1);
      chk("s4_cnt0", pkt_cnt0, 32'd0);
      chk("s4_cnt1", pkt_cnt1, 32'd1);

      // Exactly MAXB beats ending with tlast is a good packet.
      do_reset();
      push_pkt(1, MAXB, 8);
      wait_idle(300);
      chk("s5_log_size", lg.size(), MAXB);
      if (lg.size() >= MAXB) begin
         chk("s5_vw", lg[MAXB-1].vw, 1'b1);
         chk("s5_v", lg[MAXB-1].v, 1'b1);
      end
      chk("s5_err_cnt", err_cnt, 32'd0);
      chk("s5_cnt1", pkt_cnt1, 32'd1);

      // Reset arriving on beat 2 of 4 abandons the packet.
      do_reset();
      push_pkt(0, 4, 9);
      wait_log(1, 100);
      want_rst = 1'b1;
      q0.delete();
      @(posedge clk);
      @(negedge clk);
      chk("s6_wr", pktin_data_wr, 1'b0);
      chk("s6_vw", pktin_data_valid_wr, 1'b0);
      chk("s6_data", pktin_data, '0);
      chk("s6_user", pktin_user, '0);
      chk("s6_tready0", s0_axis_tready, 1'b0);
      @(posedge clk);
      want_rst = 1'b0;
      repeat (10) @(posedge clk);
      sz = lg.size();
      chk("s6_log_size", sz, 2);
      for (int i = 0; i < lg.size(); i++) chk("s6_no_eop", lg[i].vw, 1'b0);
      chk("s6_cnt0", pkt_cnt0, 32'd0);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
